b03_grant_monitor: RTL and testbench
====================================

# b03_grant_monitor

Registered monitor that sits directly downstream of the b03 round-robin arbiter and consumes its four-bit grant vector `GRANT_O` together with the raw `REQUEST1..4` lines. It tracks the current owner and counts grant events per client. It measures how long each ownership lasts and flags protocol faults: a non-one-hot grant vector, or a client waiting longer than `MAX_WAIT` cycles. Outputs feed the status/debug register bank.

## Interface
- `MAX_WAIT`, default 15: wait-cycle limit per client before the starvation flag is raised; legal range 1..255.
- `CNT_W`, default 8: width of the per-client grant counters and of the hold-length register.
- `CLOCK`  in  1  single clock; all state updates on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `REQUEST`  in  4  raw requests; bit i is client i+1 (`REQUEST1` in bit 0).
- `GRANT_O`  in  4  arbiter grant vector; bit i grants client i+1.
- `CLEAR`  in  1  synchronous clear of counters and sticky flags; does not change owner state.
- `VALID`  out  1  1 while a legal owner is registered (state OWNED).
- `OWNER`  out  2  index 0..3 of the current owner; holds its last value in IDLE.
- `GRANT_CNT0..GRANT_CNT3`  out  CNT_W each  grant-event count per client; saturating.
- `LAST_HOLD`  out  CNT_W  length in cycles of the most recently completed ownership; saturating.
- `WAIT_ERR`  out  4  sticky per-client starvation flags.
- `ONEHOT_ERR`  out  1  sticky flag: `GRANT_O` had more than one bit set.

## Operation
- Reset values: `VALID`=0, `OWNER`=0, all `GRANT_CNTi`=0, `LAST_HOLD`=0, `WAIT_ERR`=0, `ONEHOT_ERR`=0, FSM in IDLE, hold counter 0, all wait counters 0.
- Each cycle the sampled `GRANT_O` is classified as exactly one of:
  - ZERO: no bit set.
  - ONE(k): exactly bit k set.
  - MULTI: two or more bits set.
- FSM states and transitions:
  - IDLE + ZERO: stay in IDLE.
  - IDLE + ONE(k): go to OWNED; `OWNER`=k; `GRANT_CNTk`+1; hold counter=1.
  - OWNED + ONE(same k): stay; hold counter+1, saturating at 2^CNT_W-1.
  - OWNED + ONE(j≠k): handover. `LAST_HOLD`=hold counter; `OWNER`=j; `GRANT_CNTj`+1; hold counter=1; stay in OWNED.
  - OWNED + ZERO: go to IDLE; `LAST_HOLD`=hold counter; hold counter=0.
  - Any state + MULTI: set `ONEHOT_ERR`. State, `OWNER`, hold counter and grant counters are unchanged for that cycle.
- Grant counters saturate at 2^CNT_W-1 and never wrap.
- Per-client wait counter i, width ceil(log2(MAX_WAIT+1)):
  - Client i is waiting when `REQUEST[i]`=1 and `GRANT_O[i]`=0. While waiting, the counter increments, saturating at `MAX_WAIT`.
  - When client i is not waiting, the counter is 0.
  - If client i is waiting and its counter already equals `MAX_WAIT`, set `WAIT_ERR[i]`.
- `CLEAR`=1 zeroes all `GRANT_CNTi`, `LAST_HOLD`, `WAIT_ERR`, `ONEHOT_ERR` and all wait counters.
  - `CLEAR` wins over a same-cycle increment or flag set.
  - The FSM, `OWNER` and the hold counter still update normally.
- `RESET` has priority over `CLEAR` and over all input activity. Reset mid-ownership discards the hold count without writing `LAST_HOLD`.

## Timing
- All outputs are registered. Inputs sampled at rising edge N are reflected on the outputs immediately after edge N, i.e. one cycle of latency; there is no combinational input-to-output path.
- `VALID` rises the cycle after the first ONE grant is sampled and falls the cycle after ZERO is sampled.
- A handover (ONE(k) then ONE(j) on consecutive edges) produces no IDLE cycle. `VALID` stays 1; `OWNER` and `LAST_HOLD` change on the same edge.
- Starvation timing: with `REQUEST[i]` held and never granted from edge 1, the wait counter reads `MAX_WAIT` after edge `MAX_WAIT`. `WAIT_ERR[i]` is 1 after edge `MAX_WAIT`+1.
- Grant and request changes on the same edge are evaluated together. A request rising on the edge its grant appears never counts as waiting.
- There is no handshake. The block never back-pressures the arbiter.

## Test plan
- Reset, then `GRANT_O`=0010 for 5 cycles, then 0000:
  - during ownership: `VALID`=1, `OWNER`=1, `GRANT_CNT1`=1;
  - after release: `VALID`=0 and `LAST_HOLD`=5.
- Handover `GRANT_O`=0001 for 3 cycles, then 1000 for 2 cycles, then 0000:
  - at the handover: `LAST_HOLD`=3, `OWNER`=3, `VALID` stays 1 throughout;
  - final: `LAST_HOLD`=2, `GRANT_CNT0`=1, `GRANT_CNT3`=1.
- `GRANT_O`=0110 for one cycle while OWNED by 2:
  - `ONEHOT_ERR`=1; `OWNER`=2, hold count and counters unchanged;
  - `CLEAR` pulse: `ONEHOT_ERR`=0.
- `MAX_WAIT`=15, `REQUEST`=0100 held, `GRANT_O`=0:
  - `WAIT_ERR`=0000 after edge 15 and 0100 after edge 16;
  - a grant of 0100 at edge 16 instead keeps `WAIT_ERR`=0.
- `CNT_W`=8, 300 alternating grants 0001/0010:
  - `GRANT_CNT0`=`GRANT_CNT1`=150;
  - continue to 600 grants: both counters saturate at 255.
- `RESET` asserted mid-ownership with a hold count of 7: all outputs return to their reset values the next cycle, `LAST_HOLD`=0.

Source files
------------

// File: rtl/b03_grant_monitor.sv
// Grant monitor for the b03 round-robin arbiter: tracks the current owner, counts
// grants per client, measures ownership length and flags one-hot and starvation faults.
module b03_grant_monitor #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [3:0]       REQUEST,
    input  logic [3:0]       GRANT_O,
    input  logic             CLEAR,
    output logic             VALID,
    output logic [1:0]       OWNER,
    output logic [CNT_W-1:0] GRANT_CNT0,
    output logic [CNT_W-1:0] GRANT_CNT1,
    output logic [CNT_W-1:0] GRANT_CNT2,
    output logic [CNT_W-1:0] GRANT_CNT3,
    output logic [CNT_W-1:0] LAST_HOLD,
    output logic [3:0]       WAIT_ERR,
    output logic             ONEHOT_ERR
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]   last_hold_q, last_hold_d;
    logic [CNT_W-1:0]   grant_cnt_q [4];
    logic [WAIT_W-1:0]  wait_cnt_q [4];
    logic [3:0]         wait_err_q;
    logic               onehot_err_q;
    logic [3:0]         cnt_inc;

    logic [2:0]         grant_ones;
    logic [1:0]         grant_idx;
    logic               is_zero, is_one, is_multi;

    always_comb begin
        grant_idx  = 2'd0;
        grant_ones = 3'(GRANT_O[0]) + 3'(GRANT_O[1]) + 3'(GRANT_O[2]) + 3'(GRANT_O[3]);
        for (int i = 0; i < 4; i++) begin
            if (GRANT_O[i]) grant_idx = 2'(i);
        end
        is_zero  = (grant_ones == 3'd0);
        is_one   = (grant_ones == 3'd1);
        is_multi = (grant_ones > 3'd1);
    end

    // NOTE: every signal gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        hold_d      = hold_q;
        last_hold_d = last_hold_q;
        cnt_inc     = 4'b0000;
        case (state_q)
            IDLE: begin
                if (is_one) begin
                    state_d            = OWNED;
                    owner_d            = grant_idx;
                    cnt_inc[grant_idx] = 1'b1;
                    hold_d             = CNT_W'(1);
                end
            end
            OWNED: begin
                if (is_one && grant_idx == owner_q) begin
                    hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
                end else if (is_one) begin
                    last_hold_d        = hold_q;
                    owner_d            = grant_idx;
                    cnt_inc[grant_idx] = 1'b1;
                    hold_d             = CNT_W'(1);
                end else if (is_zero) begin
                    state_d     = IDLE;
                    last_hold_d = hold_q;
                    hold_d      = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= IDLE;
            owner_q      <= 2'd0;
            hold_q       <= '0;
            last_hold_q  <= '0;
            wait_err_q   <= 4'b0000;
            onehot_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                grant_cnt_q[i] <= '0;
                wait_cnt_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            // CLEAR beats any same-cycle update of counters and sticky flags.
            last_hold_q  <= CLEAR ? '0 : last_hold_d;
            onehot_err_q <= CLEAR ? 1'b0 : (onehot_err_q | is_multi);
            for (int i = 0; i < 4; i++) begin
                if (CLEAR) begin
                    grant_cnt_q[i] <= '0;
                    wait_cnt_q[i]  <= '0;
                    wait_err_q[i]  <= 1'b0;
                end else begin
                    if (cnt_inc[i] && grant_cnt_q[i] != '1)
                        grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
                    if (REQUEST[i] && !GRANT_O[i]) begin
                        if (wait_cnt_q[i] == WAIT_W'(MAX_WAIT))
                            wait_err_q[i] <= 1'b1;
                        else
                            wait_cnt_q[i] <= wait_cnt_q[i] + 1'b1;
                    end else begin
                        wait_cnt_q[i] <= '0;
                    end
                end
            end
        end
    end

    assign VALID      = (state_q == OWNED);
    assign OWNER      = owner_q;
    assign GRANT_CNT0 = grant_cnt_q[0];
    assign GRANT_CNT1 = grant_cnt_q[1];
    assign GRANT_CNT2 = grant_cnt_q[2];
    assign GRANT_CNT3 = grant_cnt_q[3];
    assign LAST_HOLD  = last_hold_q;
    assign WAIT_ERR   = wait_err_q;
    assign ONEHOT_ERR = onehot_err_q;

endmodule

// File: tb/tb_b03_grant_monitor.sv
// Self-checking bench for b03_grant_monitor: directed vectors, a per-cycle
// comparison against an abstract ownership model, and literal spot checks.
module tb_b03_grant_monitor;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             CLOCK = 1'b0;
    logic             RESET = 1'b1;
    logic             CLEAR = 1'b0;
    logic [3:0]       REQUEST = 4'b0000;
    logic [3:0]       GRANT_O = 4'b0000;
    logic             VALID;
    logic [1:0]       OWNER;
    logic [CNT_W-1:0] GRANT_CNT0, GRANT_CNT1, GRANT_CNT2, GRANT_CNT3;
    logic [CNT_W-1:0] LAST_HOLD;
    logic [3:0]       WAIT_ERR;
    logic             ONEHOT_ERR;

    int checks = 0;
    int errors = 0;

    // Abstract model: who owns the bus, for how long, and what has been seen.
    bit m_valid;
    int m_owner, m_hold, m_last, m_oherr;
    int m_cnt [4];
    int m_wait [4];
    bit [3:0] m_werr;

    b03_grant_monitor #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .REQUEST(REQUEST), .GRANT_O(GRANT_O),
        .CLEAR(CLEAR), .VALID(VALID), .OWNER(OWNER),
        .GRANT_CNT0(GRANT_CNT0), .GRANT_CNT1(GRANT_CNT1),
        .GRANT_CNT2(GRANT_CNT2), .GRANT_CNT3(GRANT_CNT3),
        .LAST_HOLD(LAST_HOLD), .WAIT_ERR(WAIT_ERR), .ONEHOT_ERR(ONEHOT_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_cnt(input int i);
        case (i)
            0: return 32'(GRANT_CNT0);
            1: return 32'(GRANT_CNT1);
            2: return 32'(GRANT_CNT2);
            default: return 32'(GRANT_CNT3);
        endcase
    endfunction

    task automatic model_update(input bit rst, input bit clr, input logic [3:0] req, input logic [3:0] gnt);
        int n, k;
        if (rst) begin
            m_valid = 0; m_owner = 0; m_hold = 0; m_last = 0; m_oherr = 0; m_werr = '0;
            for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_wait[i] = 0; end
            return;
        end
        n = $countones(gnt);
        k = 0;
        for (int i = 0; i < 4; i++) if (gnt[i]) k = i;
        if (n > 1) begin
            m_oherr = 1;
        end else if (n == 1) begin
            if (m_valid && k == m_owner) begin
                m_hold = (m_hold < CNT_MAX) ? m_hold + 1 : CNT_MAX;
            end else begin
                if (m_valid) m_last = m_hold;
                m_valid = 1;
                m_owner = k;
                m_hold  = 1;
                if (m_cnt[k] < CNT_MAX) m_cnt[k]++;
            end
        end else if (m_valid) begin
            m_valid = 0;
            m_last  = m_hold;
            m_hold  = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (req[i] && !gnt[i]) begin
                if (m_wait[i] == MAX_WAIT) m_werr[i] = 1'b1;
                else m_wait[i]++;
            end else begin
                m_wait[i] = 0;
            end
        end
        if (clr) begin
            m_last = 0; m_oherr = 0; m_werr = '0;
            for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_wait[i] = 0; end
        end
    endtask

    task automatic compare_all();
        check("valid", 32'(VALID), 32'(m_valid));
        check("owner", 32'(OWNER), 32'(m_owner));
        check("last_hold", 32'(LAST_HOLD), 32'(m_last));
        check("wait_err", 32'(WAIT_ERR), 32'(m_werr));
        check("onehot_err", 32'(ONEHOT_ERR), 32'(m_oherr));
        for (int i = 0; i < 4; i++)
            check($sformatf("grant_cnt%0d", i), dut_cnt(i), 32'(m_cnt[i]));
    endtask

    task automatic step(input bit rst, input bit clr, input logic [3:0] req, input logic [3:0] gnt);
        RESET   = rst;
        CLEAR   = clr;
        REQUEST = req;
        GRANT_O = gnt;
        @(posedge CLOCK);
        model_update(rst, clr, req, gnt);
        #1;
        compare_all();
    endtask

    task automatic repeat_step(input int n, input logic [3:0] req, input logic [3:0] gnt);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, req, gnt);
    endtask

    initial begin
        #2;
        step(1'b1, 1'b0, 4'b0000, 4'b0000);
        step(1'b1, 1'b0, 4'b0000, 4'b0000);
        check("reset_valid", 32'(VALID), 32'd0);
        check("reset_last_hold", 32'(LAST_HOLD), 32'd0);

        // Single ownership by client 1 for five cycles.
        step(1'b0, 1'b0, 4'b0000, 4'b0010);
        check("own_valid", 32'(VALID), 32'd1);
        check("own_owner", 32'(OWNER), 32'd1);
        check("own_cnt1", 32'(GRANT_CNT1), 32'd1);
        repeat_step(4, 4'b0000, 4'b0010);
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        check("rel_valid", 32'(VALID), 32'd0);
        check("rel_last_hold", 32'(LAST_HOLD), 32'd5);

        // Handover from client 0 to client 3 with no idle gap.
        repeat_step(3, 4'b0000, 4'b0001);
        step(1'b0, 1'b0, 4'b0000, 4'b1000);
        check("ho_last_hold", 32'(LAST_HOLD), 32'd3);
        check("ho_owner", 32'(OWNER), 32'd3);
        check("ho_valid", 32'(VALID), 32'd1);
        step(1'b0, 1'b0, 4'b0000, 4'b1000);
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        check("ho_final_last", 32'(LAST_HOLD), 32'd2);
        check("ho_final_cnt0", 32'(GRANT_CNT0), 32'd1);
        check("ho_final_cnt3", 32'(GRANT_CNT3), 32'd1);

        // Multi-bit grant while owned by client 2 must freeze ownership state.
        repeat_step(2, 4'b0000, 4'b0100);
        step(1'b0, 1'b0, 4'b0000, 4'b0110);
        check("multi_err", 32'(ONEHOT_ERR), 32'd1);
        check("multi_owner", 32'(OWNER), 32'd2);
        check("multi_cnt2", 32'(GRANT_CNT2), 32'd1);
        step(1'b0, 1'b0, 4'b0000, 4'b0100);
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        check("multi_hold", 32'(LAST_HOLD), 32'd3);
        step(1'b0, 1'b1, 4'b0000, 4'b0000);
        check("clr_onehot", 32'(ONEHOT_ERR), 32'd0);
        check("clr_cnt1", 32'(GRANT_CNT1), 32'd0);

        // Starvation of client 2, then a grant arriving just in time.
        repeat_step(MAX_WAIT, 4'b0100, 4'b0000);
        check("starve_pre", 32'(WAIT_ERR), 32'd0);
        step(1'b0, 1'b0, 4'b0100, 4'b0000);
        check("starve_set", 32'(WAIT_ERR), 32'b0100);
        step(1'b0, 1'b1, 4'b0000, 4'b0000);
        repeat_step(MAX_WAIT, 4'b0100, 4'b0000);
        step(1'b0, 1'b0, 4'b0100, 4'b0100);
        check("starve_saved", 32'(WAIT_ERR), 32'd0);
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        step(1'b0, 1'b1, 4'b0000, 4'b0000);

        // Alternating handovers exercise counter saturation.
        for (int n = 0; n < 300; n++)
            step(1'b0, 1'b0, 4'b0000, (n % 2 == 1) ? 4'b0010 : 4'b0001);
        check("alt300_cnt0", 32'(GRANT_CNT0), 32'd150);
        check("alt300_cnt1", 32'(GRANT_CNT1), 32'd150);
        for (int n = 300; n < 600; n++)
            step(1'b0, 1'b0, 4'b0000, (n % 2 == 1) ? 4'b0010 : 4'b0001);
        check("alt600_cnt0", 32'(GRANT_CNT0), 32'd255);
        check("alt600_cnt1", 32'(GRANT_CNT1), 32'd255);

        // Clear on the same edge as a handover: counters and LAST_HOLD lose.
        step(1'b0, 1'b1, 4'b0000, 4'b0100);
        check("clr_ho_last", 32'(LAST_HOLD), 32'd0);
        check("clr_ho_owner", 32'(OWNER), 32'd2);

        // Reset in the middle of a seven-cycle ownership.
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        repeat_step(7, 4'b0000, 4'b0100);
        step(1'b1, 1'b0, 4'b0000, 4'b0100);
        check("rst_valid", 32'(VALID), 32'd0);
        check("rst_owner", 32'(OWNER), 32'd0);
        check("rst_last_hold", 32'(LAST_HOLD), 32'd0);
        check("rst_cnt0", 32'(GRANT_CNT0), 32'd0);
        check("rst_cnt2", 32'(GRANT_CNT2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
